rf_wr_sched: RTL and testbench

- Write-port scheduler in front of the register file.
- Buffers register writes from ROB commit in a small FIFO.
- Shares the register file's single write port between ROB commit traffic and a debug/loader write requester, using round-robin arbitration.
- Presents one write per cycle, stalls when the register file flushes, and never loses an already-committed write.

---
 rtl/rf_wr_sched.sv | 125 ++++++++++++
 tb/tb_rf_wr_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_sched.sv
// Purpose : register-file write-port scheduler; buffers ROB commit writes in a small FIFO and
//           round-robins the single write port between that FIFO and a debug/loader requester.
// Latency : commit accepted at edge N (empty FIFO, port idle) is presented after edge N+1 and
//           written by the register file at edge N+2.
// Backpressure: commit_ready_out drops when the FIFO is full (no enqueue-through-full);
//           a flush holds the presented write and marks queued tags invalid; rdy_in low freezes all.
// Ports   : clk_in/rst_in (sync, active-low)/rdy_in/need_flush_in control;
//           commit_* enqueue side, dbg_* debug requester, rf_* registered write port,
//           drained_out/count_out status.
module rf_wr_sched #(
  parameter int REG_NUM_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          need_flush_in,
  input  logic                          commit_valid_in,
  input  logic [REG_NUM_WIDTH-1:0]      commit_rd_in,
  input  logic [31:0]                   commit_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0]     commit_tag_in,
  output logic                          commit_ready_out,
  input  logic                          dbg_valid_in,
  input  logic [REG_NUM_WIDTH-1:0]      dbg_rd_in,
  input  logic [31:0]                   dbg_value_in,
  output logic                          dbg_ready_out,
  output logic                          rf_valid_out,
  output logic [REG_NUM_WIDTH-1:0]      rf_rd_out,
  output logic [31:0]                   rf_value_out,
  output logic [ROB_SIZE_WIDTH-1:0]     rf_dependency_out,
  output logic                          drained_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ROB_SIZE_WIDTH-1:0] NO_DEP = '1;

  // Commit buffer storage; occupancy is tracked by count, so contents need no reset.
  logic [REG_NUM_WIDTH-1:0]  fifo_rd    [FIFO_DEPTH];
  logic [31:0]               fifo_value [FIFO_DEPTH];
  logic [ROB_SIZE_WIDTH-1:0] fifo_tag   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     fifo_stale;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          last_dbg;   // 1 = debug was granted most recently

  logic active;
  logic push;
  logic pop;
  logic arb_en;
  logic fifo_cand;
  logic grant_fifo;
  logic grant_dbg;

  assign active           = rst_in && rdy_in;
  assign commit_ready_out = active && (count < CW'(FIFO_DEPTH));
  // Writes to r0 are acknowledged but never stored.
  assign push             = commit_ready_out && commit_valid_in && (commit_rd_in != '0);

  // Without a flush the output stage is always free: either empty or consumed this edge.
  assign arb_en     = active && !need_flush_in;
  assign fifo_cand  = (count != '0);
  assign grant_fifo = arb_en && fifo_cand && (!dbg_valid_in || last_dbg);
  assign grant_dbg  = arb_en && dbg_valid_in && (!fifo_cand || !last_dbg);
  assign pop        = grant_fifo;

  assign dbg_ready_out = grant_dbg;
  assign drained_out   = (count == '0) && !rf_valid_out;
  assign count_out     = count;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      last_dbg          <= 1'b1;
      rf_valid_out      <= 1'b0;
      rf_rd_out         <= '0;
      rf_value_out      <= '0;
      rf_dependency_out <= NO_DEP;
    end else if (rdy_in) begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (grant_fifo)     last_dbg <= 1'b0;
      else if (grant_dbg) last_dbg <= 1'b1;

      if (need_flush_in) begin
        // Presented write survives the flush but its tag is no longer meaningful.
        if (rf_valid_out) rf_dependency_out <= NO_DEP;
      end else if (grant_fifo) begin
        rf_valid_out      <= 1'b1;
        rf_rd_out         <= fifo_rd[head];
        rf_value_out      <= fifo_value[head];
        rf_dependency_out <= fifo_stale[head] ? NO_DEP : fifo_tag[head];
      end else if (grant_dbg) begin
        rf_valid_out      <= (dbg_rd_in != '0);
        rf_rd_out         <= dbg_rd_in;
        rf_value_out      <= dbg_value_in;
        rf_dependency_out <= NO_DEP;
      end else begin
        rf_valid_out      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (active) begin
      if (need_flush_in) fifo_stale <= '1;
      if (push) begin
        fifo_rd[tail]    <= commit_rd_in;
        fifo_value[tail] <= commit_value_in;
        fifo_tag[tail]   <= commit_tag_in;
        // Later assignment wins for the tail bit: a commit in the flush cycle is stale too.
        fifo_stale[tail] <= need_flush_in;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_sched.sv
// Purpose : self-checking bench for rf_wr_sched: directed cycle table plus randomized traffic
//           compared against a queue-based reference model.
// Latency : one table row or random step per clock; outputs sampled on the falling edge.
// Backpressure: stimulus honours commit_ready_out only through the model's acceptance rule.
module tb_rf_wr_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        commit_valid_in;
  logic [4:0]  commit_rd_in;
  logic [31:0] commit_value_in;
  logic [2:0]  commit_tag_in;
  logic        commit_ready_out;
  logic        dbg_valid_in;
  logic [4:0]  dbg_rd_in;
  logic [31:0] dbg_value_in;
  logic        dbg_ready_out;
  logic        rf_valid_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_value_out;
  logic [2:0]  rf_dependency_out;
  logic        drained_out;
  logic [2:0]  count_out;

  always #5 clk_in = ~clk_in;

  rf_wr_sched #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(3), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .commit_valid_in(commit_valid_in), .commit_rd_in(commit_rd_in),
    .commit_value_in(commit_value_in), .commit_tag_in(commit_tag_in),
    .commit_ready_out(commit_ready_out),
    .dbg_valid_in(dbg_valid_in), .dbg_rd_in(dbg_rd_in), .dbg_value_in(dbg_value_in),
    .dbg_ready_out(dbg_ready_out),
    .rf_valid_out(rf_valid_out), .rf_rd_out(rf_rd_out), .rf_value_out(rf_value_out),
    .rf_dependency_out(rf_dependency_out), .drained_out(drained_out), .count_out(count_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit rst, rdy, fl, cv;
    logic [4:0] crd; logic [31:0] cval; logic [2:0] ctag;
    bit dv; logic [4:0] drd; logic [31:0] dval;
    bit e_crdy, e_drdy, e_vld;
    logic [4:0] e_rd; logic [31:0] e_val; logic [2:0] e_dep; logic [2:0] e_cnt; bit e_drn;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rdy, bit fl, bit cv, logic [4:0] crd, logic [31:0] cval,
                              logic [2:0] ctag, bit dv, logic [4:0] drd, logic [31:0] dval,
                              bit ecr, bit edr, bit evld, logic [4:0] erd, logic [31:0] evl,
                              logic [2:0] edep, logic [2:0] ecnt, bit edrn);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.fl = fl; t.cv = cv; t.crd = crd; t.cval = cval; t.ctag = ctag;
    t.dv = dv; t.drd = drd; t.dval = dval;
    t.e_crdy = ecr; t.e_drdy = edr; t.e_vld = evld; t.e_rd = erd; t.e_val = evl;
    t.e_dep = edep; t.e_cnt = ecnt; t.e_drn = edrn;
    return t;
  endfunction

  // Idle-input row: only the expectations vary.
  function automatic vec_t idle(bit ecr, bit edr, bit evld, logic [4:0] erd, logic [31:0] evl,
                                logic [2:0] edep, logic [2:0] ecnt, bit edrn);
    return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, ecr, edr, evld, erd, evl, edep, ecnt, edrn);
  endfunction

  // Reference model: commit queue, presented write, and who was granted last.
  typedef struct {
    logic [4:0] rd; logic [31:0] val; logic [2:0] tag; bit stale;
  } ent_t;
  ent_t        mq[$];
  bit          m_vld = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_val = 0;
  logic [2:0]  m_tag = 3'd7;
  bit          m_last_dbg = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    rst_in = t.rst; rdy_in = t.rdy; need_flush_in = t.fl;
    commit_valid_in = t.cv; commit_rd_in = t.crd; commit_value_in = t.cval; commit_tag_in = t.ctag;
    dbg_valid_in = t.dv; dbg_rd_in = t.drd; dbg_value_in = t.dval;
  endtask

  task automatic model_predict(output bit crdy, output bit dgnt, output bit fgnt);
    bit act;
    act  = rst_in && rdy_in;
    crdy = act && (mq.size() < 4);
    dgnt = 0;
    fgnt = 0;
    if (act && !need_flush_in) begin
      if (mq.size() > 0 && (!dbg_valid_in || m_last_dbg)) fgnt = 1;
      else if (dbg_valid_in) dgnt = 1;
    end
  endtask

  task automatic model_step();
    bit crdy, dg, fg;
    ent_t e;
    if (!rst_in) begin
      mq.delete();
      m_vld = 0; m_rd = 0; m_val = 0; m_tag = 3'd7; m_last_dbg = 1;
    end else if (rdy_in) begin
      model_predict(crdy, dg, fg);
      if (need_flush_in) begin
        if (m_vld) m_tag = 3'd7;
        foreach (mq[i]) mq[i].stale = 1;
      end else if (fg) begin
        e = mq.pop_front();
        m_vld = 1; m_rd = e.rd; m_val = e.val; m_tag = e.stale ? 3'd7 : e.tag;
        m_last_dbg = 0;
      end else if (dg) begin
        m_vld = (dbg_rd_in != 0); m_rd = dbg_rd_in; m_val = dbg_value_in; m_tag = 3'd7;
        m_last_dbg = 1;
      end else begin
        m_vld = 0;
      end
      if (commit_valid_in && crdy && commit_rd_in != 0) begin
        e.rd = commit_rd_in; e.val = commit_value_in; e.tag = commit_tag_in;
        e.stale = need_flush_in;
        mq.push_back(e);
      end
    end
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic do_cycle(input bit use_tab, input vec_t t, input string nm);
    bit pc, pd, pf;
    bit ev, edrn, chk_s;
    logic [4:0] erd; logic [31:0] evl; logic [2:0] edep, ecnt;
    #1;
    model_predict(pc, pd, pf);
    if (use_tab) begin
      chk({nm, " commit_ready"}, 32'(commit_ready_out), 32'(t.e_crdy));
      chk({nm, " dbg_ready"},    32'(dbg_ready_out),    32'(t.e_drdy));
    end else begin
      chk({nm, " commit_ready"}, 32'(commit_ready_out), 32'(pc));
      chk({nm, " dbg_ready"},    32'(dbg_ready_out),    32'(pd));
    end
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    if (use_tab) begin
      ev = t.e_vld; erd = t.e_rd; evl = t.e_val; edep = t.e_dep; ecnt = t.e_cnt; edrn = t.e_drn;
      chk_s = t.e_vld || !t.rst;
    end else begin
      ev = m_vld; erd = m_rd; evl = m_val; edep = m_tag; ecnt = 3'(mq.size());
      edrn = (mq.size() == 0) && !m_vld; chk_s = m_vld;
    end
    chk({nm, " rf_valid"}, 32'(rf_valid_out), 32'(ev));
    chk({nm, " count"},    32'(count_out),    32'(ecnt));
    chk({nm, " drained"},  32'(drained_out),  32'(edrn));
    if (chk_s) begin
      chk({nm, " rf_rd"},    32'(rf_rd_out),         32'(erd));
      chk({nm, " rf_value"}, rf_value_out,           evl);
      chk({nm, " rf_dep"},   32'(rf_dependency_out), 32'(edep));
    end
  endtask

  initial begin
    vec_t tab[$];
    vec_t r;

    // rst,rdy,fl,cv,crd,cval,ctag,dv,drd,dval | crdy,drdy,vld,rd,val,dep,cnt,drained
    // Reset held two cycles with requests present: no acceptance, no grant.
    tab.push_back(mk(0,1,0,1,4,32'h44,1,1,9,32'h99, 0,0,0,0,0,7,0,1));
    tab.push_back(mk(0,1,0,1,4,32'h44,1,1,9,32'h99, 0,0,0,0,0,7,0,1));
    // Single commit: accepted at N, presented after N+1, drained after N+2.
    tab.push_back(mk(1,1,0,1,5,32'hDEADBEEF,2,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(idle(1,0,1,5,32'hDEADBEEF,2,0,0));
    tab.push_back(idle(1,0,0,0,0,0,0,1));
    // r0 commit and r0 debug write: acknowledged, dropped.
    tab.push_back(mk(1,1,0,1,0,32'h1,1,0,0,0, 1,0,0,0,0,0,0,1));
    tab.push_back(mk(1,1,0,0,0,0,0,1,0,32'h5, 1,1,0,0,0,0,0,1));
    // Round robin: FIFO rd1,rd2 vs continuous debug rd9 -> 1,9,2,9.
    tab.push_back(mk(1,1,0,1,1,32'h11,3,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(mk(1,1,0,1,2,32'h22,5,1,9,32'h99, 1,0,1,1,32'h11,3,1,0));
    tab.push_back(mk(1,1,0,0,0,0,0,1,9,32'h99, 1,1,1,9,32'h99,7,1,0));
    tab.push_back(mk(1,1,0,0,0,0,0,1,9,32'h99, 1,0,1,2,32'h22,5,0,0));
    tab.push_back(mk(1,1,0,0,0,0,0,1,9,32'h99, 1,1,1,9,32'h99,7,0,0));
    tab.push_back(idle(1,0,0,0,0,0,0,1));
    // Flush on presented write rd3/tag4: held with tag 7, consumed next edge.
    tab.push_back(mk(1,1,0,1,3,32'h33,4,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(idle(1,0,1,3,32'h33,4,0,0));
    tab.push_back(mk(1,1,1,0,0,0,0,0,0,0, 1,0,1,3,32'h33,7,0,0));
    tab.push_back(idle(1,0,0,0,0,0,0,1));
    // Full FIFO behind a flush-held write; fifth commit refused; drain in order, tags 7.
    tab.push_back(mk(1,1,0,1,10,32'hA0,1,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(idle(1,0,1,10,32'hA0,1,0,0));
    tab.push_back(mk(1,1,1,1,11,32'hA1,2,0,0,0, 1,0,1,10,32'hA0,7,1,0));
    tab.push_back(mk(1,1,1,1,12,32'hA2,3,0,0,0, 1,0,1,10,32'hA0,7,2,0));
    tab.push_back(mk(1,1,1,1,13,32'hA3,4,0,0,0, 1,0,1,10,32'hA0,7,3,0));
    tab.push_back(mk(1,1,1,1,14,32'hA4,5,0,0,0, 1,0,1,10,32'hA0,7,4,0));
    tab.push_back(mk(1,1,1,1,15,32'hA5,6,0,0,0, 0,0,1,10,32'hA0,7,4,0));
    tab.push_back(idle(0,0,1,11,32'hA1,7,3,0));
    tab.push_back(idle(1,0,1,12,32'hA2,7,2,0));
    tab.push_back(idle(1,0,1,13,32'hA3,7,1,0));
    tab.push_back(idle(1,0,1,14,32'hA4,7,0,0));
    tab.push_back(idle(1,0,0,0,0,0,0,1));
    // rdy_in low freezes queue and presented write.
    tab.push_back(mk(1,0,0,1,7,32'h77,1,1,8,32'h88, 0,0,0,0,0,0,0,1));
    tab.push_back(mk(1,1,0,1,7,32'h77,1,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0));
    tab.push_back(idle(1,0,1,7,32'h77,1,0,0));
    tab.push_back(mk(1,0,0,0,0,0,0,1,8,32'h88, 0,0,1,7,32'h77,1,0,0));
    tab.push_back(idle(1,0,0,0,0,0,0,1));
    // Reset mid-operation discards the queued commit.
    tab.push_back(mk(1,1,0,1,6,32'h66,2,0,0,0, 1,0,0,0,0,0,1,0));
    tab.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,7,0,1));
    tab.push_back(idle(1,0,0,0,0,0,0,1));

    apply(idle(0,0,0,0,0,0,0,0));
    @(negedge clk_in);
    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i]);
      do_cycle(1, tab[i], $sformatf("vec%0d", i));
    end

    // Randomized traffic against the model, starting from a fresh reset.
    for (int i = 0; i < 3000; i++) begin
      r = idle(0,0,0,0,0,0,0,0);
      r.rst  = (i < 2) ? 1'b0 : ($urandom_range(99) != 0);
      r.rdy  = ($urandom_range(9) != 0);
      r.fl   = ($urandom_range(9) == 0);
      r.cv   = ($urandom_range(9) < 6);
      r.crd  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      r.cval = $urandom;
      r.ctag = 3'($urandom_range(7));
      r.dv   = ($urandom_range(9) < 3);
      r.drd  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      r.dval = $urandom;
      apply(r);
      do_cycle(0, r, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
